gfx_pixel_serializer: RTL and testbench
=======================================

GFX_PIXEL_SERIALIZER -- requirements
Module: gfx_pixel_serializer

Interface
REQ-001 Parameter FETCH_W, default 16: bits per fetch word; legal values 8, 16, 32.
REQ-002 Parameter COLOR_W, default 4: width of palette entries, border colour and video output.
REQ-003 Port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 Port reset_n  input  1: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 Port cfg_bpp  input  2: bits per pixel; 0=1bpp, 1=2bpp, 2=4bpp; 3 is treated as 4bpp.
REQ-006 Port cfg_rep  input  2: clocks per pixel; 0=1, 1=2, 2=4; 3 is treated as 4.
REQ-007 Port fetch_data  input  FETCH_W: packed pixel word, MSB-first.
REQ-008 Port fetch_valid  input  1: fetch_data is valid.
REQ-009 Port fetch_ready  output  1: the holding register is empty; a word transfers when fetch_valid and fetch_ready are both high.
REQ-010 Port display_enable  input  1: active-area qualifier.
REQ-011 Port border_color  input  COLOR_W: overscan colour, bypasses the palette.
REQ-012 Port pal_we  input  1; pal_addr  input  4; pal_data  input  COLOR_W: palette write port.
REQ-013 Port underrun  output  1: sticky flag for shifter starvation.
REQ-014 Port underrun_clr  input  1: clears underrun.
REQ-015 Port video  output  COLOR_W: registered pixel colour.

Function
REQ-016 Datapath SHALL be: one-entry holding register -> shift register -> pixel-index mux -> 16-entry palette -> registered video.
REQ-017 fetch_ready SHALL equal "holding register empty"; the holding register fills on a transfer and empties when its word moves to the shifter; fill and empty in the same cycle SHALL leave it full with the new word.
REQ-018 Shifter load: when display_enable=1, the shifter is empty or finishing its last repeat of its last pixel, and the holding register is full, the shifter SHALL load the holding word. At the same time it SHALL latch cfg_bpp and cfg_rep, and set pixel count = FETCH_W/bpp and repeat count = rep.
REQ-019 Current pixel index SHALL be the top bpp bits of the shifter, zero-extended to 4 bits.
REQ-020 Repeat counter: each index SHALL be held for the latched rep clocks. After the last repeat, the shifter SHALL shift left by the latched bpp and pixel count SHALL decrement.
REQ-021 Config changes SHALL take effect only at the next shifter load; a word in flight keeps its latched mode.
REQ-022 Underrun: if display_enable=1 and the shifter is empty with no holding word available, the shifter SHALL output index 0 and underrun SHALL be set. underrun SHALL stay set until underrun_clr; if underrun_clr and a new underrun occur in the same cycle, underrun SHALL remain set.
REQ-023 When display_enable=0, the shifter SHALL flush (pixel count=0, remaining pixels discarded), the holding register SHALL be retained, and no underrun SHALL be flagged.
REQ-024 Output latency: video at cycle n+1 SHALL be palette[index at cycle n] if display_enable was 1 at cycle n, else border_color at cycle n.
REQ-025 Palette write: the entry SHALL update at the clock edge. A lookup of the same address in the write cycle SHALL return the old value; the new value SHALL apply from the next cycle.
REQ-026 Writes SHALL be accepted at any time, including during active display.
REQ-027 Throughput: with cfg_rep=0, FETCH_W=16, 1bpp, a new word is needed every 16 clocks. Back-to-back words SHALL produce gapless pixels when fetch_valid is asserted at least 1 cycle before shifter exhaustion.

Reset
REQ-028 While reset_n=0 at a clock edge, the following SHALL hold after that edge:
- holding register and shifter empty;
- fetch_ready=0 during reset and 1 on the first cycle after release;
- underrun=0; video=0; latched mode=1bpp, rep 1;
- palette[i]=i for i=0..15.
REQ-029 Reset asserted mid-line SHALL discard all buffered pixels, with no underrun flagged.

Verification
REQ-030 FETCH_W=16, 2bpp, rep=1, word 16'hE4E4, palette identity, display_enable=1 -> video sequence 3,2,1,0,3,2,1,0 starting 1 cycle after load, then index 0 with underrun=1.
REQ-031 4bpp, rep=4 (cfg 2), word 16'h1234, palette[1]=4'hA -> video A,A,A,A,2,2,2,2,3,3,3,3,4,4,4,4.
REQ-032 display_enable drops after 3 of 16 1bpp pixels, border_color=4'h5 -> video=5 next cycle, remaining pixels discarded, underrun stays 0, holding word retained for next line.
REQ-033 Palette write addr 3 data 4'hC in the same cycle index 3 is displayed -> old colour for that pixel, C from the next cycle.
REQ-034 cfg_bpp changed 0->2 mid-word -> current word finishes in 1bpp; next word displays in 4bpp.
REQ-035 reset_n=0 mid-line with full holding register -> fetch_ready=0, video=0; after release fetch_ready=1, palette identity, underrun=0.

Source files
------------

// File: rtl/gfx_pixel_serializer.sv
// gfx_pixel_serializer: holding register -> shifter -> palette -> registered video pixel stream
module gfx_pixel_serializer #(
  parameter int FETCH_W = 16,
  parameter int COLOR_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         cfg_bpp,
  input  logic [1:0]         cfg_rep,
  input  logic [FETCH_W-1:0] fetch_data,
  input  logic               fetch_valid,
  output logic               fetch_ready,
  input  logic               display_enable,
  input  logic [COLOR_W-1:0] border_color,
  input  logic               pal_we,
  input  logic [3:0]         pal_addr,
  input  logic [COLOR_W-1:0] pal_data,
  output logic               underrun,
  input  logic               underrun_clr,
  output logic [COLOR_W-1:0] video
);
  localparam int CW = $clog2(FETCH_W + 1);
  logic [FETCH_W-1:0] hold_q, hold_d, shift_q, shift_d;
  logic               hold_full_q, hold_full_d;
  logic [CW-1:0]      pcnt_q, pcnt_d;
  logic [1:0]         rcnt_q, rcnt_d, bpp_q, bpp_d, rep_q, rep_d;
  logic               underrun_q, underrun_d;
  logic [COLOR_W-1:0] video_q, video_d;
  logic [COLOR_W-1:0] pal_q [16];
  logic [COLOR_W-1:0] pal_d [16];
  logic [1:0]         bsel, rsel, rinit, rmax;
  logic [3:0]         idx;
  logic               fill, load, active, last_rep;
  assign fetch_ready = reset_n & ~hold_full_q;
  assign underrun    = underrun_q;
  assign video       = video_q;
  always_comb begin
    bsel        = (cfg_bpp == 2'd3) ? 2'd2 : cfg_bpp;
    rsel        = (cfg_rep == 2'd3) ? 2'd2 : cfg_rep;
    rinit       = (rsel == 2'd0) ? 2'd0 : (rsel == 2'd1) ? 2'd1 : 2'd3;
    rmax        = (rep_q == 2'd0) ? 2'd0 : (rep_q == 2'd1) ? 2'd1 : 2'd3;
    fill        = fetch_valid & fetch_ready;
    active      = display_enable & (pcnt_q != '0);
    last_rep    = rcnt_q == 2'd0;
    // Reloading on the final repeat of the final pixel keeps back-to-back words gapless
    load        = display_enable & hold_full_q & ((pcnt_q == '0) | ((pcnt_q == CW'(1)) & last_rep));
    idx         = !active ? 4'd0 :
                  (bpp_q == 2'd0) ? {3'b000, shift_q[FETCH_W-1]} :
                  (bpp_q == 2'd1) ? {2'b00, shift_q[FETCH_W-1 -: 2]} : shift_q[FETCH_W-1 -: 4];
    hold_full_d = fill | (hold_full_q & ~load);
    hold_d      = fill ? fetch_data : hold_q;
    shift_d     = load ? hold_q : (active & last_rep) ? shift_q << (4'd1 << bpp_q) : shift_q;
    pcnt_d      = !display_enable ? '0 : load ? CW'(FETCH_W >> bsel) :
                  (active & last_rep) ? pcnt_q - CW'(1) : pcnt_q;
    rcnt_d      = load ? rinit : active ? (last_rep ? rmax : rcnt_q - 2'd1) : rcnt_q;
    bpp_d       = load ? bsel : bpp_q;
    rep_d       = load ? rsel : rep_q;
    underrun_d  = (underrun_q & ~underrun_clr) | (display_enable & (pcnt_q == '0) & ~hold_full_q);
    video_d     = display_enable ? pal_q[idx] : border_color;
    pal_d       = pal_q;
    if (pal_we) pal_d[pal_addr] = pal_data;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      pcnt_q      <= '0;
      rcnt_q      <= 2'd0;
      bpp_q       <= 2'd0;
      rep_q       <= 2'd0;
      underrun_q  <= 1'b0;
      video_q     <= '0;
      for (int i = 0; i < 16; i++) pal_q[i] <= COLOR_W'(i);
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      pcnt_q      <= pcnt_d;
      rcnt_q      <= rcnt_d;
      bpp_q       <= bpp_d;
      rep_q       <= rep_d;
      underrun_q  <= underrun_d;
      video_q     <= video_d;
      pal_q       <= pal_d;
    end
  end
endmodule

// File: tb/tb_gfx_pixel_serializer.sv
// tb_gfx_pixel_serializer: directed checks of pixel serialization, palette, underrun and reset
module tb_gfx_pixel_serializer;
  logic        clk = 1'b0;
  logic        reset_n, fetch_valid, fetch_ready, display_enable, pal_we, underrun, underrun_clr;
  logic [1:0]  cfg_bpp, cfg_rep;
  logic [15:0] fetch_data;
  logic [3:0]  border_color, pal_addr, pal_data, video;
  int          errors = 0, checks = 0;
  logic [15:0] w;
  logic [3:0]  e;
  gfx_pixel_serializer #(.FETCH_W(16), .COLOR_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_bpp(cfg_bpp), .cfg_rep(cfg_rep),
    .fetch_data(fetch_data), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .display_enable(display_enable), .border_color(border_color),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
    .underrun(underrun), .underrun_clr(underrun_clr), .video(video)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [15:0] d);
    fetch_data = d;
    fetch_valid = 1'b1;
    tick();
    fetch_valid = 1'b0;
  endtask
  initial begin
    reset_n = 1'b0; cfg_bpp = 2'd0; cfg_rep = 2'd0; fetch_data = '0; fetch_valid = 1'b0;
    display_enable = 1'b0; border_color = 4'h0; pal_we = 1'b0; pal_addr = '0; pal_data = '0;
    underrun_clr = 1'b0;
    tick(); tick();
    chk("rst_ready", fetch_ready, 0);
    chk("rst_video", video, 0);
    chk("rst_underrun", underrun, 0);
    reset_n = 1'b1;
    tick();
    chk("ready_after_release", fetch_ready, 1);
    // 2bpp identity: E4E4 -> 3,2,1,0,3,2,1,0 then underrun
    cfg_bpp = 2'd1;
    push(16'hE4E4);
    chk("hold_full_ready", fetch_ready, 0);
    display_enable = 1'b1;
    tick();
    chk("load_cycle_video", video, 0);
    chk("ready_after_load", fetch_ready, 1);
    w = 16'hE4E4;
    for (int i = 0; i < 8; i++) begin
      tick();
      e = {2'b00, w[15-2*i -: 2]};
      chk($sformatf("bpp2_px%0d", i), video, e);
    end
    chk("no_underrun_yet", underrun, 0);
    tick();
    chk("underrun_video", video, 0);
    chk("underrun_set", underrun, 1);
    underrun_clr = 1'b1;
    tick();
    chk("clr_vs_new_underrun", underrun, 1);
    display_enable = 1'b0;
    tick();
    chk("underrun_cleared", underrun, 0);
    underrun_clr = 1'b0;
    // 4bpp, 4 clocks per pixel, palette[1]=A
    pal_we = 1'b1; pal_addr = 4'd1; pal_data = 4'hA;
    tick();
    pal_we = 1'b0;
    cfg_bpp = 2'd2; cfg_rep = 2'd2;
    push(16'h1234);
    display_enable = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      tick();
      e = (i < 4) ? 4'hA : (i < 8) ? 4'h2 : (i < 12) ? 4'h3 : 4'h4;
      chk($sformatf("rep4_px%0d", i), video, e);
    end
    display_enable = 1'b0; border_color = 4'h5;
    pal_we = 1'b1; pal_addr = 4'd1; pal_data = 4'h1;
    tick();
    pal_we = 1'b0;
    chk("rep4_border", video, 5);
    chk("rep4_no_underrun", underrun, 0);
    // display_enable drops after 3 of 16 1bpp pixels
    cfg_bpp = 2'd0; cfg_rep = 2'd0;
    push(16'hA5F0);
    display_enable = 1'b1;
    tick();
    fetch_data = 16'h8000; fetch_valid = 1'b1;
    tick();
    fetch_valid = 1'b0;
    chk("de_px0", video, 1);
    tick();
    chk("de_px1", video, 0);
    tick();
    chk("de_px2", video, 1);
    display_enable = 1'b0;
    tick();
    chk("de_border", video, 5);
    chk("de_no_underrun", underrun, 0);
    chk("de_hold_retained", fetch_ready, 0);
    tick();
    chk("de_border2", video, 5);
    display_enable = 1'b1;
    tick();
    tick();
    chk("next_line_px0", video, 1);
    tick();
    chk("next_line_px1", video, 0);
    chk("next_line_no_underrun", underrun, 0);
    display_enable = 1'b0;
    tick();
    // palette write collides with displayed index 3
    cfg_bpp = 2'd1;
    push(16'hFFFF);
    display_enable = 1'b1;
    tick();
    pal_we = 1'b1; pal_addr = 4'd3; pal_data = 4'hC;
    tick();
    pal_we = 1'b0;
    chk("pal_old_value", video, 3);
    tick();
    chk("pal_new_value", video, 4'hC);
    tick();
    chk("pal_new_value2", video, 4'hC);
    display_enable = 1'b0;
    pal_we = 1'b1; pal_data = 4'h3;
    tick();
    pal_we = 1'b0;
    // bpp change mid-word: F0F0 stays 1bpp, 9ABC follows gaplessly in 4bpp
    cfg_bpp = 2'd0;
    push(16'hF0F0);
    display_enable = 1'b1;
    tick();
    cfg_bpp = 2'd2;
    fetch_data = 16'h9ABC; fetch_valid = 1'b1;
    w = 16'hF0F0;
    for (int i = 0; i < 16; i++) begin
      tick();
      fetch_valid = 1'b0;
      e = {3'b000, w[15-i]};
      chk($sformatf("mode_old_px%0d", i), video, e);
    end
    w = 16'h9ABC;
    for (int i = 0; i < 4; i++) begin
      tick();
      e = w[15-4*i -: 4];
      chk($sformatf("mode_new_px%0d", i), video, e);
    end
    chk("mode_no_underrun", underrun, 0);
    display_enable = 1'b0;
    tick();
    // reset mid-line with a full holding register
    cfg_bpp = 2'd0;
    push(16'hFFFF);
    display_enable = 1'b1;
    tick();
    fetch_data = 16'hFFFF; fetch_valid = 1'b1;
    pal_we = 1'b1; pal_addr = 4'd5; pal_data = 4'h0;
    tick();
    fetch_valid = 1'b0; pal_we = 1'b0;
    chk("pre_reset_video", video, 1);
    chk("pre_reset_full", fetch_ready, 0);
    reset_n = 1'b0;
    tick();
    chk("midreset_ready", fetch_ready, 0);
    chk("midreset_video", video, 0);
    chk("midreset_underrun", underrun, 0);
    reset_n = 1'b1; display_enable = 1'b0;
    tick();
    chk("post_reset_ready", fetch_ready, 1);
    chk("post_reset_underrun", underrun, 0);
    cfg_bpp = 2'd2;
    push(16'h5F00);
    display_enable = 1'b1;
    tick();
    tick();
    chk("post_reset_pal5", video, 5);
    tick();
    chk("post_reset_palF", video, 4'hF);
    chk("post_reset_no_underrun", underrun, 0);
    display_enable = 1'b0;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
